// File: rtl/tmds_pkg.sv
// Shared constants, lock-FSM state type and token helpers for the TMDS lane deserializer.
package tmds_pkg;

  localparam int unsigned SYM_W = 10;
  localparam int unsigned PH_W  = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(9);

  localparam logic [SYM_W-1:0] TOKEN_C0 = 10'h354;
  localparam logic [SYM_W-1:0] TOKEN_C1 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOKEN_C2 = 10'h154;
  localparam logic [SYM_W-1:0] TOKEN_C3 = 10'h2AB;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  function automatic logic is_token(input logic [SYM_W-1:0] sym);
    return (sym == TOKEN_C0) || (sym == TOKEN_C1) ||
           (sym == TOKEN_C2) || (sym == TOKEN_C3);
  endfunction

  // Control bits {C1,C0} carried by each token; only meaningful when is_token().
  function automatic logic [1:0] token_ctl(input logic [SYM_W-1:0] sym);
    logic [1:0] ctl;
    ctl = 2'b00;
    case (sym)
      TOKEN_C1: ctl = 2'b01;
      TOKEN_C2: ctl = 2'b10;
      TOKEN_C3: ctl = 2'b11;
      default:  ctl = 2'b00;
    endcase
    return ctl;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tmds_decode_8b.sv
// Registered DVI 10b->8b decoder: tokens give control bits, other symbols give a data byte.
module tmds_decode_8b
  import tmds_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             word_valid_i,
  output logic [7:0]       byte_o,
  output logic [1:0]       ctl_o,
  output logic             de_o,
  output logic             dec_valid_o
);

  logic [7:0] byte_q, byte_d, byte_c;
  logic [7:0] din_c;
  logic [1:0] ctl_q, ctl_d;
  logic       de_q, de_d;
  logic       dec_valid_q;

  // Undo the optional inversion, then the XOR/XNOR chain selected by bit 8.
  always_comb begin
    din_c     = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    byte_c    = '0;
    byte_c[0] = din_c[0];
    for (int i = 1; i < 8; i++) begin
      byte_c[i] = sym_i[8] ? (din_c[i] ^ din_c[i-1]) : ~(din_c[i] ^ din_c[i-1]);
    end
  end

  always_comb begin
    byte_d = byte_q;
    ctl_d  = ctl_q;
    de_d   = de_q;
    if (word_valid_i) begin
      if (is_token(sym_i)) begin
        byte_d = '0;
        ctl_d  = token_ctl(sym_i);
        de_d   = 1'b0;
      end else begin
        byte_d = byte_c;
        de_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      byte_q      <= '0;
      ctl_q       <= '0;
      de_q        <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      byte_q      <= byte_d;
      ctl_q       <= ctl_d;
      de_q        <= de_d;
      dec_valid_q <= word_valid_i;
    end
  end

  assign byte_o      = byte_q;
  assign ctl_o       = ctl_q;
  assign de_o        = de_q;
  assign dec_valid_o = dec_valid_q;

endmodule

// File: rtl/tmds_deserializer_1_10.sv
// One-lane TMDS 1:10 deserializer with control-token boundary lock.
// Define TMDS_DECODE_EN to add the registered DVI 8b/10b decode outputs.
module tmds_deserializer_1_10
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Serial_In,
  output logic [SYM_W-1:0] Data,
  output logic             Word_Valid,
  output logic             Token,
  output logic             Locked,
  output logic             Realign
`ifdef TMDS_DECODE_EN
  ,
  output logic [7:0]       Byte,
  output logic [1:0]       Ctl,
  output logic             De,
  output logic             Dec_Valid
`endif
);

  logic [SYM_W-1:0] sr_q, sr_d;
  logic [SYM_W-1:0] data_q, data_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  lock_state_e      state_q, state_d;
  logic             word_valid_q, word_valid_d;
  logic             token_q, token_d;
  logic             locked_q, locked_d;
  logic             realign_q, realign_d;
  logic             token_hit_c, aligned_c;

  always_comb begin
    sr_d         = {Serial_In, sr_q[SYM_W-1:1]};
    token_hit_c  = is_token(sr_q);
    aligned_c    = token_hit_c && (phase_q == '0);
    phase_d      = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    data_d       = data_q;
    word_valid_d = 1'b0;
    token_d      = 1'b0;
    state_d      = state_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    realign_d    = 1'b0;

    if (phase_q == PHASE_LAST) begin
      data_d       = sr_d;
      word_valid_d = 1'b1;
      token_d      = is_token(sr_d);
    end

    case (state_q)
      HUNT: begin
        if (token_hit_c) begin
          realign_d = 1'b1;
          hit_d     = CNT_W'(1);
          if (LOCK_COUNT <= 1) begin
            state_d = LOCKED;
            miss_d  = '0;
          end else begin
            state_d = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (aligned_c) begin
          hit_d = sat_inc(hit_q);
          if (hit_d >= CNT_W'(LOCK_COUNT)) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end else if (token_hit_c) begin
          realign_d = 1'b1;
          hit_d     = CNT_W'(1);
        end
      end
      LOCKED: begin
        // Once locked, stray tokens are only counted; the boundary is never moved here.
        if (aligned_c) begin
          miss_d = '0;
        end else if (token_hit_c) begin
          miss_d = sat_inc(miss_q);
          if (miss_d >= CNT_W'(LOSS_COUNT)) begin
            state_d = HUNT;
            hit_d   = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // The token just seen ends a symbol, so the next one completes 10 bits from now.
    if (realign_d) begin
      phase_d = PH_W'(1);
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sr_q         <= '0;
      data_q       <= '0;
      phase_q      <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      state_q      <= HUNT;
      word_valid_q <= 1'b0;
      token_q      <= 1'b0;
      locked_q     <= 1'b0;
      realign_q    <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      data_q       <= data_d;
      phase_q      <= phase_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      state_q      <= state_d;
      word_valid_q <= word_valid_d;
      token_q      <= token_d;
      locked_q     <= locked_d;
      realign_q    <= realign_d;
    end
  end

  assign Data       = data_q;
  assign Word_Valid = word_valid_q;
  assign Token      = token_q;
  assign Locked     = locked_q;
  assign Realign    = realign_q;

`ifdef TMDS_DECODE_EN
  tmds_decode_8b u_decode (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .sym_i        (data_q),
    .word_valid_i (word_valid_q),
    .byte_o       (Byte),
    .ctl_o        (Ctl),
    .de_o         (De),
    .dec_valid_o  (Dec_Valid)
  );
`endif

endmodule

// File: tb/tb_tmds_deserializer_1_10.sv
// Bench for tmds_deserializer_1_10: scripted lock/slip/reset scenarios plus random symbol streams
// checked every cycle against a bit-count based model of the lane.
`timescale 1ns/1ps
module tb_tmds_deserializer_1_10;

  localparam int unsigned LOCK_N = 4;
  localparam int unsigned LOSS_N = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Serial_In;
  logic [9:0] Data;
  logic       Word_Valid, Token, Locked, Realign;
`ifdef TMDS_DECODE_EN
  logic [7:0] Byte;
  logic [1:0] Ctl;
  logic       De, Dec_Valid;
`endif

  tmds_deserializer_1_10 #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Serial_In  (Serial_In),
    .Data       (Data),
    .Word_Valid (Word_Valid),
    .Token      (Token),
    .Locked     (Locked),
    .Realign    (Realign)
`ifdef TMDS_DECODE_EN
    ,
    .Byte       (Byte),
    .Ctl        (Ctl),
    .De         (De),
    .Dec_Valid  (Dec_Valid)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bits seen since reset, and the bit count at which the current symbol grid started.
  logic [9:0] m_win;
  int         m_n, m_b, m_st, m_hc, m_mc;
  logic [9:0] e_data;
  logic       e_wv, e_tok, e_locked, e_realign;
`ifdef TMDS_DECODE_EN
  logic [7:0] e_byte;
  logic [1:0] e_ctl;
  logic       e_de, e_dv;
`endif

  int         rcount;
  logic [9:0] last_data;
  logic       last_tok;

  typedef struct {
    bit          pre_reset;
    int unsigned slip;
    logic        slip_bit;
    logic [9:0]  sym;
    int unsigned nsym;
    logic        exp_locked;
    int unsigned exp_realigns;
    bit          chk_data;
    logic [9:0]  exp_data;
    logic        exp_token;
  } rec_t;

  rec_t       recs[6];
  logic [9:0] toks[4];

  function automatic bit is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

`ifdef TMDS_DECODE_EN
  function automatic logic [1:0] ctl_of(input logic [9:0] w);
    if (w == 10'h0AB) return 2'b01;
    if (w == 10'h154) return 2'b10;
    if (w == 10'h2AB) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [7:0] dvi_dec(input logic [9:0] w);
    logic [7:0] d, q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = (d[i] == d[i-1]) ? ~w[8] : w[8];
    return q;
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_win = '0; m_n = 0; m_b = 0; m_st = 0; m_hc = 0; m_mc = 0;
    e_data = '0; e_wv = 0; e_tok = 0; e_locked = 0; e_realign = 0;
`ifdef TMDS_DECODE_EN
    e_byte = '0; e_ctl = '0; e_de = 0; e_dv = 0;
`endif
  endtask

  task automatic model_update(input logic b);
    logic [9:0] nw;
    bit hit, al;
`ifdef TMDS_DECODE_EN
    e_dv = e_wv;
    if (e_wv) begin
      if (is_tok(e_data)) begin
        e_de = 0; e_byte = '0; e_ctl = ctl_of(e_data);
      end else begin
        e_de = 1; e_byte = dvi_dec(e_data);
      end
    end
`endif
    hit  = is_tok(m_win);
    al   = hit && (((m_n - m_b) % 10) == 0);
    nw   = {b, m_win[9:1]};
    e_wv = (((m_n + 1 - m_b) % 10) == 0);
    e_tok = e_wv && is_tok(nw);
    if (e_wv) e_data = nw;
    e_realign = 0;
    case (m_st)
      0: if (hit) begin
           e_realign = 1; m_hc = 1;
           if (LOCK_N <= 1) begin m_st = 2; m_mc = 0; end else m_st = 1;
         end
      1: if (al) begin
           if (m_hc < 15) m_hc++;
           if (m_hc >= int'(LOCK_N)) begin m_st = 2; m_mc = 0; end
         end else if (hit) begin
           e_realign = 1; m_hc = 1;
         end
      default: if (al) m_mc = 0;
         else if (hit) begin
           if (m_mc < 15) m_mc++;
           if (m_mc >= int'(LOSS_N)) begin m_st = 0; m_hc = 0; end
         end
    endcase
    if (e_realign) m_b = m_n;
    e_locked = (m_st == 2);
    m_win = nw;
    m_n++;
  endtask

  // Called at a falling edge; drives one bit, checks after the rising edge, returns at the next fall.
  task automatic step(input logic b);
    Serial_In = b;
    @(posedge Clk);
    model_update(b);
    #1;
    check("word_valid", 32'(Word_Valid), 32'(e_wv));
    check("realign", 32'(Realign), 32'(e_realign));
    check("locked", 32'(Locked), 32'(e_locked));
    check("token", 32'(Token), 32'(e_tok));
    if (e_wv) check("data", 32'(Data), 32'(e_data));
`ifdef TMDS_DECODE_EN
    check("dec_valid", 32'(Dec_Valid), 32'(e_dv));
    if (e_dv) begin
      check("dec_de", 32'(De), 32'(e_de));
      check("dec_ctl", 32'(Ctl), 32'(e_ctl));
      check("dec_byte", 32'(Byte), 32'(e_byte));
    end
`endif
    if (Realign) rcount++;
    if (Word_Valid) begin last_data = Data; last_tok = Token; end
    @(negedge Clk);
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) step(s[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, 32'(Data), 32'd0);
    check({tag, "_word_valid"}, 32'(Word_Valid), 32'd0);
    check({tag, "_token"}, 32'(Token), 32'd0);
    check({tag, "_locked"}, 32'(Locked), 32'd0);
    check({tag, "_realign"}, 32'(Realign), 32'd0);
  endtask

  // Four bits into a symbol, pull reset between edges and hold it for three cycles.
  task automatic reset_mid_symbol();
    logic [9:0] part;
    part = 10'h354;
    for (int i = 0; i < 4; i++) step(part[i]);
    #1 Reset_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("reset_word_valid", 32'(Word_Valid), 32'd0);
    end
    model_reset();
    Reset_n = 1'b1;
  endtask

  initial begin
    toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
    recs[0] = '{pre_reset:0, slip:3, slip_bit:1'b0, sym:10'h354, nsym:6,
                exp_locked:1'b1, exp_realigns:1, chk_data:1, exp_data:10'h354, exp_token:1'b1};
    recs[1] = '{pre_reset:0, slip:0, slip_bit:1'b0, sym:10'h1F0, nsym:20,
                exp_locked:1'b1, exp_realigns:0, chk_data:1, exp_data:10'h1F0, exp_token:1'b0};
    recs[2] = '{pre_reset:0, slip:1, slip_bit:1'b0, sym:10'h0AB, nsym:3,
                exp_locked:1'b1, exp_realigns:0, chk_data:0, exp_data:10'h000, exp_token:1'b0};
    recs[3] = '{pre_reset:0, slip:9, slip_bit:1'b0, sym:10'h0AB, nsym:2,
                exp_locked:1'b1, exp_realigns:0, chk_data:1, exp_data:10'h0AB, exp_token:1'b1};
    recs[4] = '{pre_reset:0, slip:1, slip_bit:1'b0, sym:10'h0AB, nsym:9,
                exp_locked:1'b1, exp_realigns:1, chk_data:1, exp_data:10'h0AB, exp_token:1'b1};
    recs[5] = '{pre_reset:1, slip:3, slip_bit:1'b0, sym:10'h354, nsym:6,
                exp_locked:1'b1, exp_realigns:1, chk_data:1, exp_data:10'h354, exp_token:1'b1};

    Reset_n   = 1'b0;
    Serial_In = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_outputs_zero("reset");
    Reset_n = 1'b1;

    foreach (recs[r]) begin
      if (recs[r].pre_reset) reset_mid_symbol();
      rcount = 0;
      for (int unsigned k = 0; k < recs[r].slip; k++) step(recs[r].slip_bit);
      for (int unsigned k = 0; k < recs[r].nsym; k++) send_sym(recs[r].sym);
      check($sformatf("rec%0d_locked", r), 32'(Locked), 32'(recs[r].exp_locked));
      check($sformatf("rec%0d_realigns", r), 32'(rcount), 32'(recs[r].exp_realigns));
      if (recs[r].chk_data) begin
        check($sformatf("rec%0d_data", r), 32'(last_data), 32'(recs[r].exp_data));
        check($sformatf("rec%0d_token", r), 32'(last_tok), 32'(recs[r].exp_token));
      end
    end

    // Control period ending in a data symbol, exercising the decode path when present.
    send_sym(10'h154);
    send_sym(10'h2AB);
    send_sym(10'h100);
    send_sym(10'h100);
    check("post_data_locked", 32'(Locked), 32'd1);
    check("post_data_word", 32'(last_data), 32'h100);

    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        int unsigned nslip;
        nslip = $urandom_range(1, 9);
        for (int unsigned k = 0; k < nslip; k++) step(1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 9) < 5) send_sym(toks[$urandom_range(0, 3)]);
      else send_sym(10'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
